stage_fetch_queue: RTL

- Instruction queue between the fetch stage and decode.
- Captures each (PC, instruction word) pair returned by instruction memory one cycle after fetch presents an address.
- Buffers up to DEPTH entries and presents them to decode with a valid/ready handshake.
- Drives the fetch stall input to prevent overflow; discards all wrong-path entries on a redirect.

---
 rtl/stage_fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/stage_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : stage_fetch_queue
//  Purpose  : Instruction queue between fetch and decode. Each cycle that
//             memory returns a fresh word, the (fetch_pc, mem_rdata) pair is
//             pushed into a DEPTH-entry circular buffer. The head entry is
//             handed to decode with a valid/ready handshake. The queue
//             back-pressures fetch through stall_out, and a flush discards
//             every wrong-path entry plus the in-flight response.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             fetch_pc         - address of the word on mem_rdata this cycle
//             mem_rdata        - registered instruction word from memory
//             flush            - redirect from execute; kills queue contents
//             stall_out        - hold request to the fetch stage
//             dec_valid/dec_pc/dec_instr/dec_ready - decode handshake
//  Options  : FETCH_QUEUE_BYPASS_EN - when defined, a word arriving at an
//             empty queue is presented to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module stage_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        stall_out,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready
);

    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rsp_valid;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_head_valid;
    logic [CNT_W:0]   w_occupancy;

    assign w_empty      = (r_count == '0);
    assign w_head_valid = ~w_empty & ~flush;

    // Occupancy including the word that may arrive next edge. Stalling on
    // this sum (without crediting a same-cycle pop) guarantees a free slot
    // for the response that is already in flight.
    assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rsp_valid};
    assign stall_out    = rst | (~flush & (w_occupancy >= (CNT_W + 1)'(DEPTH)));

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;

    // Empty queue with a fresh word: forward it straight to decode. If decode
    // takes it, it never touches storage.
    assign w_bypass  = w_empty & r_rsp_valid & ~flush;
    assign dec_valid = w_head_valid | w_bypass;
    assign dec_pc    = w_bypass ? fetch_pc  : r_pc_mem[r_rd_ptr];
    assign dec_instr = w_bypass ? mem_rdata : r_instr_mem[r_rd_ptr];
    assign w_push    = r_rsp_valid & ~flush & ~(w_bypass & dec_ready);
    assign w_pop     = w_head_valid & dec_ready;
`else
    assign dec_valid = w_head_valid;
    assign dec_pc    = r_pc_mem[r_rd_ptr];
    assign dec_instr = r_instr_mem[r_rd_ptr];
    assign w_push    = r_rsp_valid & ~flush;
    assign w_pop     = w_head_valid & dec_ready;
`endif

    // A word returned after a stalled cycle duplicates one already captured,
    // so only words following an unstalled cycle are marked fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= ~stall_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= fetch_pc;
            r_instr_mem[r_wr_ptr] <= mem_rdata;
        end
    end

endmodule
`default_nettype wire
